// File: rtl/ddr_cmd_sequencer.sv
// rtl/ddr_cmd_sequencer.sv - single-bank-at-a-time DDR command sequencer (ACT/RCD/RD|WR/PRE/RP)
//
// Ports:
//   clk2x, rst_n                    clock and asynchronous active-low reset
//   cfg_burst_len, cfg_burst_type   burst config (1/2/3 = BL2/4/8; 0 seq, 1 interleaved)
//   req_*                           request handshake and address/direction
//   abort                           stop the running RD/WR burst
//   wdata, wdata_ready              write beat data in, consumed flag
//   rdata, rdata_valid              read beat data out, one cycle after each RD beat
//   busy                            sequencer not idle
//   mem_*                           memory-side command, address and data signals
module ddr_cmd_sequencer #(
  parameter int ROW_WIDTH = 14,
  parameter int COL_WIDTH = 10,
  parameter int TRCD      = 2,
  parameter int TRP       = 2
) (
  input  logic                 clk2x,
  input  logic                 rst_n,
  input  logic [2:0]           cfg_burst_len,
  input  logic                 cfg_burst_type,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [1:0]           req_ba,
  input  logic [ROW_WIDTH-1:0] req_row,
  input  logic [COL_WIDTH-1:0] req_col,
  input  logic                 abort,
  input  logic [15:0]          wdata,
  output logic                 wdata_ready,
  output logic [15:0]          rdata,
  output logic                 rdata_valid,
  output logic                 busy,
  output logic [1:0]           mem_ba,
  output logic [ROW_WIDTH-1:0] mem_ra,
  output logic [COL_WIDTH-1:0] mem_ca,
  output logic [3:0]           mem_row_active,
  output logic                 mem_read_active,
  output logic                 mem_write_active,
  output logic                 mem_burst_stop,
  output logic [2:0]           mem_burst_len,
  output logic                 mem_burst_type,
  output logic [15:0]          mem_data_in,
  input  logic [15:0]          mem_data_out
);

  typedef enum logic [2:0] {S_IDLE, S_ACT, S_RCD, S_RD, S_WR, S_PRE, S_RP} state_t;

  // Terminal counts; RCD_LAST is unused when TRCD == 1 because RCD is skipped.
  localparam logic [7:0] RCD_LAST = 8'(TRCD - 2);
  localparam logic [7:0] RP_LAST  = 8'(TRP - 1);

  state_t               state, state_nx;
  logic [7:0]           cnt, cnt_nx;
  logic                 lat_write;
  logic [1:0]           lat_ba;
  logic [ROW_WIDTH-1:0] lat_row;
  logic [COL_WIDTH-1:0] lat_col;
  logic [2:0]           lat_len;
  logic                 lat_type;

  logic                 cfg_ok;
  logic                 accept;
  logic                 in_data;
  logic                 row_open;
  logic [7:0]           beat_last;
  state_t               data_state;

  assign cfg_ok     = (cfg_burst_len != 3'd0) && (cfg_burst_len <= 3'd3);
  assign accept     = req_valid && req_ready;
  assign in_data    = (state == S_RD) || (state == S_WR);
  assign row_open   = (state != S_IDLE) && (state != S_RP);
  // BL = 2^len, so the last beat index is 2^len - 1.
  assign beat_last  = (8'd1 << lat_len) - 8'd1;
  assign data_state = lat_write ? S_WR : S_RD;

  always_ff @(posedge clk2x or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nx = S_ACT;
          cnt_nx   = 8'd0;
        end
      end
      S_ACT: begin
        cnt_nx   = 8'd0;
        state_nx = (TRCD > 1) ? S_RCD : data_state;
      end
      S_RCD: begin
        if (cnt == RCD_LAST) begin
          state_nx = data_state;
          cnt_nx   = 8'd0;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      S_RD, S_WR: begin
        // An aborted beat is never issued, so PRE follows immediately.
        if (abort || (cnt == beat_last)) begin
          state_nx = S_PRE;
          cnt_nx   = 8'd0;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      S_PRE: begin
        state_nx = S_RP;
        cnt_nx   = 8'd0;
      end
      S_RP: begin
        if (cnt == RP_LAST) begin
          state_nx = S_IDLE;
          cnt_nx   = 8'd0;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk2x or negedge rst_n) begin
    if (!rst_n) begin
      lat_write <= 1'b0;
      lat_ba    <= 2'd0;
      lat_row   <= '0;
      lat_col   <= '0;
      lat_len   <= 3'd0;
      lat_type  <= 1'b0;
    end else if (accept) begin
      lat_write <= req_write;
      lat_ba    <= req_ba;
      lat_row   <= req_row;
      lat_col   <= req_col;
      lat_len   <= cfg_burst_len;
      lat_type  <= cfg_burst_type;
    end
  end

  // Read data returns one cycle after the RD beat that requested it.
  always_ff @(posedge clk2x or negedge rst_n) begin
    if (!rst_n) begin
      rdata_valid <= 1'b0;
      rdata       <= 16'd0;
    end else begin
      rdata_valid <= mem_read_active;
      rdata       <= mem_read_active ? mem_data_out : 16'd0;
    end
  end

  assign req_ready        = (state == S_IDLE) && cfg_ok;
  assign busy             = (state != S_IDLE);
  assign mem_row_active   = row_open ? (4'b0001 << lat_ba) : 4'b0000;
  assign mem_read_active  = (state == S_RD) && !abort;
  assign mem_write_active = (state == S_WR) && !abort;
  assign wdata_ready      = mem_write_active;
  assign mem_burst_stop   = in_data && abort;
  assign mem_ba           = busy ? lat_ba   : 2'd0;
  assign mem_ra           = busy ? lat_row  : '0;
  assign mem_ca           = busy ? lat_col  : '0;
  assign mem_burst_len    = busy ? lat_len  : 3'd0;
  assign mem_burst_type   = busy ? lat_type : 1'b0;
  assign mem_data_in      = (state == S_WR) ? wdata : 16'd0;

endmodule
